// File: rtl/rv_core_pkg.sv
// Shared core definitions: default datapath widths, the hard-wired zero register
// index, and the {rd, data} result bus record used by the ALU and LSU.
package rv_core_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for outstanding loads, WAW issue stall and sticky
// protocol-error detection for the writeback unit.
module wb_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic                     issue_ready,
  input  logic                     alu_fire,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic                     lsu_fire,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  output logic [2**ADDR_WIDTH-1:0] busy_mask,
  output logic                     err
);

  localparam int NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             issue_fire;

  assign issue_ready = !busy_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;

  // The set is applied after the clear so a new issue wins over a returning load.
  always_comb begin
    busy_d = busy_q;
    if (lsu_fire) begin
      busy_d[lsu_rd] = 1'b0;
    end
    if (issue_fire && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
    end
    err_d = err_q
          | (alu_fire && busy_q[alu_rd])
          | (lsu_fire && lsu_rd != '0 && !busy_q[lsu_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask = busy_q;
  assign err       = err_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write front end: LSU-over-ALU arbitration into one registered
// write port, load scoreboard, and bypass of the in-flight write to decode.
module reg_writeback_unit
  import rv_core_pkg::wb_req_t;
  import rv_core_pkg::REG_ZERO;
#(
  parameter int ADDR_WIDTH = rv_core_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = rv_core_pkg::DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy_mask,
  input  logic [ADDR_WIDTH-1:0]    byp_raddr1,
  input  logic [ADDR_WIDTH-1:0]    byp_raddr2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [DATA_WIDTH-1:0]    byp_data1,
  output logic [DATA_WIDTH-1:0]    byp_data2,
  output logic                     err
);

  wb_req_t                alu_req, lsu_req, sel_req;
  logic                   alu_fire, lsu_fire, accept;
  logic                   wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  assign lsu_ready = 1'b1;
  assign alu_ready = !lsu_valid;
  assign lsu_fire  = lsu_valid;
  assign alu_fire  = alu_valid && alu_ready;
  assign accept    = lsu_fire || alu_fire;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};

  // x0 results are consumed but never reach the register file; address/data
  // only move on a real write so they hold their last value otherwise.
  always_comb begin
    sel_req = lsu_valid ? lsu_req : alu_req;
    wen_d   = accept && (sel_req.rd != REG_ZERO);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wen_d) begin
      waddr_d = sel_req.rd;
      wdata_d = sel_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  assign byp_hit1  = wen_q && (waddr_q != '0) && (waddr_q == byp_raddr1);
  assign byp_hit2  = wen_q && (waddr_q != '0) && (waddr_q == byp_raddr2);
  assign byp_data1 = byp_hit1 ? wdata_q : '0;
  assign byp_data2 = byp_hit2 ? wdata_q : '0;

  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_fire    (alu_fire),
    .alu_rd      (alu_rd),
    .lsu_fire    (lsu_fire),
    .lsu_rd      (lsu_rd),
    .busy_mask   (busy_mask),
    .err         (err)
  );

endmodule
